// File: rtl/snake_step_controller.sv
// Snake game sequencer: move tick, direction latch, body shift register with
// wall/self collision detection, IDLE/RUN/DEAD game FSM and a segment read port.
`timescale 1ns/1ps
module snake_step_controller #(
    parameter int TICK_DIV  = 50000000,
    parameter int COLS      = 16,
    parameter int ROWS      = 8,
    parameter int MAX_LEN   = 8,
    parameter int START_LEN = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] switch,
    input  logic       start,
    input  logic       grow,
    output logic       step,
    output logic [1:0] state,
    output logic       game_over,
    output logic [3:0] head_x,
    output logic [2:0] head_y,
    output logic [3:0] length,
    input  logic [2:0] seg_rd_idx,
    output logic [3:0] seg_rd_x,
    output logic [2:0] seg_rd_y,
    output logic       seg_rd_valid
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;
    // bit 1 selects the axis, bit 0 the sense, so opposites differ only in bit 0
    typedef enum logic [1:0] {D_RIGHT = 2'd0, D_LEFT = 2'd1, D_DOWN = 2'd2, D_UP = 2'd3} dir_t;

    localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

    state_t      state_q, state_d;
    dir_t        dir_q, dir_d, pend_q, pend_d, sw_dir_s;
    logic [31:0] cnt_q, cnt_d;
    logic        step_q, step_d, game_over_q, grow_q, grow_d;
    logic [3:0]  len_q, len_d, lim_s;
    logic [3:0]  seg_x_q [MAX_LEN];
    logic [3:0]  seg_x_d [MAX_LEN];
    logic [2:0]  seg_y_q [MAX_LEN];
    logic [2:0]  seg_y_d [MAX_LEN];
    logic [4:0]  nx_s;
    logic [3:0]  ny_s;
    logic        sw_valid_s, wall_s, self_s, growing_s, moved_s;

    function automatic logic [3:0] init_x(input int i);
        if (i < START_LEN) return 4'(7 - i);
        else return 4'd0;
    endfunction

    function automatic logic [2:0] init_y(input int i);
        if (i < START_LEN) return 3'd3;
        else return 3'd0;
    endfunction

    function automatic logic opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    // decode a one-hot direction request
    always_comb begin
        sw_valid_s = 1'b1;
        sw_dir_s   = D_RIGHT;
        case (switch)
            4'b1000: sw_dir_s = D_UP;
            4'b0100: sw_dir_s = D_DOWN;
            4'b0010: sw_dir_s = D_LEFT;
            4'b0001: sw_dir_s = D_RIGHT;
            default: sw_valid_s = 1'b0;
        endcase
    end

    // candidate head position and collision tests; out-of-grid values wrap to large unsigned numbers
    always_comb begin
        nx_s = {1'b0, seg_x_q[0]};
        ny_s = {1'b0, seg_y_q[0]};
        case (pend_q)
            D_RIGHT: nx_s = {1'b0, seg_x_q[0]} + 5'd1;
            D_LEFT:  nx_s = {1'b0, seg_x_q[0]} - 5'd1;
            D_DOWN:  ny_s = {1'b0, seg_y_q[0]} + 4'd1;
            D_UP:    ny_s = {1'b0, seg_y_q[0]} - 4'd1;
            default: nx_s = {1'b0, seg_x_q[0]};
        endcase
        wall_s    = (nx_s >= 5'(COLS)) || (ny_s >= 4'(ROWS));
        growing_s = (grow_q || grow) && (len_q < 4'(MAX_LEN));
        lim_s     = growing_s ? len_q : (len_q - 4'd1);
        self_s    = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((4'(i) < lim_s) && (nx_s[3:0] == seg_x_q[i]) && (ny_s[2:0] == seg_y_q[i])) self_s = 1'b1;
            else self_s = self_s;
        end
    end

    // game FSM, tick counter, direction/grow latching and body update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        pend_d  = pend_q;
        grow_d  = grow_q;
        len_d   = len_q;
        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        moved_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 32'd0;
                if (grow) grow_d = 1'b1;
                else grow_d = grow_q;
                if (sw_valid_s && !opposite(sw_dir_s, dir_q)) pend_d = sw_dir_s;
                else pend_d = pend_q;
                if (start) state_d = ST_RUN;
                else state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_q == LAST) begin
                    cnt_d = 32'd0;
                    if (wall_s || self_s) begin
                        state_d = ST_DEAD;
                    end else begin
                        moved_s = 1'b1;
                        step_d  = 1'b1;
                        dir_d   = pend_q;
                        for (int i = MAX_LEN - 1; i > 0; i--) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = nx_s[3:0];
                        seg_y_d[0] = ny_s[2:0];
                        if (growing_s) len_d = len_q + 4'd1;
                        else len_d = len_q;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                // validate against the direction that is in force after this edge
                if (sw_valid_s && !opposite(sw_dir_s, dir_d)) pend_d = sw_dir_s;
                else pend_d = pend_q;
                if (moved_s) grow_d = 1'b0;
                else if (grow) grow_d = 1'b1;
                else grow_d = grow_q;
            end
            ST_DEAD: begin
                if (start) begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                    dir_d   = D_RIGHT;
                    pend_d  = D_RIGHT;
                    grow_d  = 1'b0;
                    len_d   = 4'(START_LEN);
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x_d[i] = init_x(i);
                        seg_y_d[i] = init_y(i);
                    end
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            step_q      <= 1'b0;
            game_over_q <= 1'b0;
            dir_q       <= D_RIGHT;
            pend_q      <= D_RIGHT;
            grow_q      <= 1'b0;
            len_q       <= 4'(START_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            game_over_q <= (state_d == ST_DEAD);
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            grow_q      <= grow_d;
            len_q       <= len_d;
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
        end
    end

    assign step         = step_q;
    assign state        = state_q;
    assign game_over    = game_over_q;
    assign head_x       = seg_x_q[0];
    assign head_y       = seg_y_q[0];
    assign length       = len_q;
    assign seg_rd_x     = seg_x_q[seg_rd_idx];
    assign seg_rd_y     = seg_y_q[seg_rd_idx];
    assign seg_rd_valid = ({1'b0, seg_rd_idx} < len_q);

endmodule
